// File: rtl/burst_addr_accum_pkg.sv
// Shared definitions for the gated phase/address accumulator of the function generator.
// Default widths are shared with the waveform RAM and the gated-signal stage.
package burst_addr_accum_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFinish = 2'd2,
    StHold   = 2'd3
  } state_e;

  localparam int unsigned AfgAccW  = 32;
  localparam int unsigned AfgAddrW = 12;
  localparam int unsigned AfgCntW  = 16;

endpackage

// File: rtl/burst_addr_accum_if.sv
// Control/address bundle between the accumulator and its controller.
// The master side drives gate and frequency controls; the slave side returns addresses.
interface burst_addr_accum_if
  import burst_addr_accum_pkg::*;
#(
  parameter int unsigned ACC_W  = AfgAccW,
  parameter int unsigned ADDR_W = AfgAddrW,
  parameter int unsigned CNT_W  = AfgCntW
);

  logic              gate;
  logic [ACC_W-1:0]  freq_word;
  logic              freq_load;
  logic              burst_mode;
  logic [CNT_W-1:0]  burst_count;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic              ba_carry_out;
  logic              burst_done;

  modport master (
    output gate, freq_word, freq_load, burst_mode, burst_count,
    input  addr_out, addr_valid, ba_carry_out, burst_done
  );

  modport slave (
    input  gate, freq_word, freq_load, burst_mode, burst_count,
    output addr_out, addr_valid, ba_carry_out, burst_done
  );

endinterface

// File: rtl/burst_period_cnt.sv
// Burst period counter: counts completed periods against a latched limit and
// flags the carry that completes the final period of a burst.
module burst_period_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             carry_pulse,
  input  logic             limit_load,
  input  logic [CNT_W-1:0] limit,
  input  logic             burst_mode,
  output logic             done_hit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W:0]   cnt_plus;
  logic             burst_active;

  // One bit wider so a saturated count can never alias onto a small limit.
  assign cnt_plus     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign burst_active = burst_mode && (limit_q != '0);

  always_comb begin
    done_hit = carry_pulse && burst_active && (cnt_plus == {1'b0, limit_q});
    cnt_d    = cnt_q;
    limit_d  = limit_q;
    if (limit_load) begin
      limit_d = limit;
    end
    if (clear) begin
      cnt_d = '0;
    end else if (carry_pulse && (cnt_q != '1)) begin
      cnt_d = cnt_plus[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

endmodule

// File: rtl/burst_addr_accum.sv
// Gated phase accumulator producing waveform-memory read addresses, a wrap
// carry pulse for gate alignment, and optional N-period burst operation.
module burst_addr_accum
  import burst_addr_accum_pkg::*;
#(
  parameter int unsigned ACC_W  = AfgAccW,
  parameter int unsigned ADDR_W = AfgAddrW,
  parameter int unsigned CNT_W  = AfgCntW
) (
  input logic               clk,
  input logic               rst,
  burst_addr_accum_if.slave bus
);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] incr_q, incr_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic [ACC_W:0]   sum;
  logic             accumulating;
  logic             carry;
  logic             start;
  logic             done_hit;

  assign accumulating = (state_q == StRun) || (state_q == StFinish);
  assign sum          = {1'b0, acc_q} + {1'b0, incr_q};
  assign carry        = accumulating && sum[ACC_W];
  assign start        = (state_q == StIdle) && bus.gate;

  burst_period_cnt #(
    .CNT_W (CNT_W)
  ) u_period_cnt (
    .clk         (clk),
    .rst         (rst),
    .clear       (start),
    .carry_pulse (carry),
    .limit_load  (start),
    .limit       (bus.burst_count),
    .burst_mode  (bus.burst_mode),
    .done_hit    (done_hit)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.gate) state_d = StRun;
      end
      StRun: begin
        if (done_hit)       state_d = StHold;
        else if (!bus.gate) state_d = StFinish;
      end
      StFinish: begin
        // A wrap always closes the period, even if the gate came back on that edge.
        if (done_hit)      state_d = StHold;
        else if (carry)    state_d = StIdle;
        else if (bus.gate) state_d = StRun;
      end
      StHold: begin
        if (!bus.gate) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    incr_d  = bus.freq_load ? bus.freq_word : incr_q;
    acc_d   = '0;
    carry_d = carry;
    done_d  = done_hit;
    valid_d = (state_d == StRun) || (state_d == StFinish);
    // Leaving the running states parks the phase at zero.
    if (accumulating && valid_d) begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      incr_q  <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      incr_q  <= incr_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign bus.addr_out     = acc_q[ACC_W-1 -: ADDR_W];
  assign bus.addr_valid   = valid_q;
  assign bus.ba_carry_out = carry_q;
  assign bus.burst_done   = done_q;

endmodule

// File: doc/burst_addr_accum.md
Name: burst_addr_accum

Overview:
- Gated phase/address accumulator that generates the waveform-memory read address for the arbitrary function generator.
- Runs while the gate signal from the gated-signal stage is high.
- Emits a one-cycle carry pulse each time the address wraps. That pulse feeds the gated-signal stage's BA_Carry_in, so gate release is aligned to a period boundary.
- Optional burst mode stops after N complete periods.

Parameters:
- ACC_W, 32: accumulator width (frequency resolution).
- ADDR_W, 12: waveform memory address width. Addr_Out is the top ADDR_W bits of the accumulator; ADDR_W <= ACC_W.
- CNT_W, 16: burst period counter width.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Gate  in  1  run request; driven by GES_OUT of the gated-signal stage.
- Freq_Word  in  ACC_W  phase increment per clock.
- Freq_Load  in  1  when high, Freq_Word is captured into the internal increment register.
- Burst_Mode  in  1  0 = continuous, 1 = burst.
- Burst_Count  in  CNT_W  number of periods per burst; 0 in burst mode is treated as continuous.
- Addr_Out  out  ADDR_W  waveform memory address = acc[ACC_W-1 -: ADDR_W].
- Addr_Valid  out  1  Addr_Out is a live sample address.
- BA_Carry_out  out  1  one-cycle pulse on accumulator wrap.
- Burst_Done  out  1  one-cycle pulse when the final burst period completes.

Behaviour:
- Reset values: acc = 0, incr = 0, cnt = 0, state = IDLE, Addr_Out = 0, Addr_Valid = 0, BA_Carry_out = 0, Burst_Done = 0.
  - Reset is asynchronous; it aborts any state immediately, mid-period included.
- Increment register:
  - Loaded on any clock edge with Freq_Load = 1, in any state.
  - A new value is used from the next accumulate cycle onward. No phase reset.
- States: IDLE, RUN, FINISH, HOLD. All outputs are registered.
- IDLE:
  - acc held at 0; Addr_Valid = 0.
  - Gate = 1 -> RUN. On that edge, latch Burst_Count into the limit register and clear cnt.
- RUN:
  - Every cycle: {carry, acc} <= acc + incr (ACC_W+1-bit sum; modulo 2^ACC_W wrap); Addr_Valid = 1.
  - The first address after entry is 0, presented in the first RUN cycle. acc begins advancing on the following edge.
  - BA_Carry_out is registered with the wrap. It is high in the same cycle Addr_Out shows the wrapped value.
  - Burst counting (Burst_Mode = 1, limit != 0):
    - Each carry increments cnt.
    - When the carry that makes cnt == limit occurs: assert BA_Carry_out and Burst_Done together, clear acc to 0, go to HOLD.
  - Gate = 0 while in RUN -> FINISH. Accumulation continues without interruption.
- FINISH:
  - Keep accumulating; Addr_Valid = 1.
  - On the next carry: pulse BA_Carry_out, clear acc, go to IDLE. The current period always completes.
  - If Gate returns to 1 before that carry -> RUN. No phase discontinuity.
  - In burst mode, a carry that reaches the limit takes precedence: Burst_Done pulses and the FSM goes to HOLD.
- HOLD:
  - acc = 0; Addr_Valid = 0.
  - Wait for Gate = 0, then -> IDLE. This prevents a retrigger until the gate is re-armed.
- incr = 0 in RUN:
  - Address is frozen and no carry is generated.
  - FINISH will not exit while incr = 0; this is legal and the FSM waits.
- Simultaneous events:
  - Freq_Load on a carry edge: the carry is computed with the old incr.
  - Gate falling on a burst-completion edge: go to HOLD, then IDLE on the next cycle.
- Counter wrap: cnt saturates at all-ones in continuous mode and never wraps.

Decomposition:
- Shared include afg_defs.vh holds:
  - state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FINISH = 2'd2, ST_HOLD = 2'd3;
  - default widths AFG_ACC_W and AFG_ADDR_W, shared with the waveform RAM and the gated-signal stage.
- One sub-module, burst_period_cnt, owns the CNT_W counter, limit latch, saturate logic and done compare.
  - Inputs: Clock, Reset, clear, carry_pulse, limit_load.
  - Output: done_hit.
- Accumulator and FSM stay in the top module.

Test Plan:
All scenarios use ACC_W = 8 and ADDR_W = 4.
1. Reset mid-RUN (acc = 0x80, Reset pulsed asynchronously between edges) -> all outputs 0 immediately; IDLE after release.
2. Continuous run: Freq_Word = 0x40 loaded, Gate = 1 -> Addr_Out 0, 4, 8, C, 0; BA_Carry_out high on every 4th address (0 after C); Addr_Valid = 1 throughout.
3. Graceful stop: Freq_Word = 0x40, Gate dropped while Addr_Out = 4 -> addresses 8, C continue, carry pulses with 0, then Addr_Valid = 0 and IDLE.
4. Burst: Burst_Mode = 1, Burst_Count = 3, Freq_Word = 0x80 -> exactly 3 carries; Burst_Done pulses with the 3rd carry; HOLD until Gate = 0. Gate held high produces no restart.
5. Frequency change: run at 0x40, load 0x20 on the edge where acc becomes 0x80 -> next acc values 0xA0, 0xC0. Check that carry timing uses the old increment when loaded on the wrap edge.
6. Gate re-asserted in FINISH before the carry -> returns to RUN with no carry glitch and an unbroken address sequence.
